// File: rtl/hazard_unit.sv
// Pipeline hazard control: combinational stall/flush/forward from per-stage fields, plus a memory-wait FSM.
// Zero-latency controls; a pending M-stage access freezes F..M until memreadyM, with sticky timeout error.
module hazard_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             bneD,
    input  logic             jumpD,
    input  logic             pcsrcD,
    input  logic             memreqM,
    input  logic             memreadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memerr,
    output logic [CNT_W-1:0] stallcnt
);
    localparam int WC_W = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, MEMWAIT, ERROR} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   waitcnt_q, waitcnt_d;
    logic              memerr_q, memerr_d;
    logic [CNT_W-1:0]  stallcnt_q, stallcnt_d;

    logic lwstall, branchstall, memstall;

    always_comb begin
        forwardAE = 2'b00;
        if (rsE != 5'd0 && regwriteM && rsE == writeregM)      forwardAE = 2'b10;
        else if (rsE != 5'd0 && regwriteW && rsE == writeregW) forwardAE = 2'b01;
        forwardBE = 2'b00;
        if (rtE != 5'd0 && regwriteM && rtE == writeregM)      forwardBE = 2'b10;
        else if (rtE != 5'd0 && regwriteW && rtE == writeregW) forwardBE = 2'b01;
    end

    assign forwardAD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
    assign forwardBD = (rtD != 5'd0) && regwriteM && (rtD == writeregM);

    assign lwstall     = memtoregE && (rtE == rsD || rtE == rtD);
    assign branchstall = (branchD || bneD) &&
                         ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                          (memtoregM && (writeregM == rsD || writeregM == rtD)));
    assign memstall    = (state_q == IDLE && memreqM && !memreadyM) ||
                         state_q == MEMWAIT || state_q == ERROR;

    // A memory stall holds ID-EX, so it must override the bubble a data hazard would insert.
    assign stallF = lwstall || branchstall || memstall;
    assign stallD = stallF;
    assign stallE = memstall;
    assign stallM = memstall;
    assign flushW = memstall;
    assign flushE = (lwstall || branchstall) && !memstall;
    assign flushD = (pcsrcD || jumpD) && !stallD;

    assign memerr   = memerr_q;
    assign stallcnt = stallcnt_q;

    always_comb begin
        state_d    = state_q;
        waitcnt_d  = waitcnt_q;
        memerr_d   = memerr_q;
        stallcnt_d = stallcnt_q;
        case (state_q)
            IDLE: begin
                if (memreqM && !memreadyM) begin
                    state_d   = MEMWAIT;
                    waitcnt_d = WC_W'(1);
                end
            end
            MEMWAIT: begin
                if (memreadyM) begin
                    state_d   = IDLE;
                    waitcnt_d = '0;
                end else if (waitcnt_q == WC_W'(MAX_WAIT - 1)) begin
                    state_d  = ERROR;
                    memerr_d = 1'b1;
                end else begin
                    waitcnt_d = waitcnt_q + WC_W'(1);
                end
            end
            ERROR:   memerr_d = 1'b1;
            default: state_d  = IDLE;
        endcase
        if ((stallF || stallE) && stallcnt_q != {CNT_W{1'b1}})
            stallcnt_d = stallcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            waitcnt_q  <= '0;
            memerr_q   <= 1'b0;
            stallcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitcnt_q  <= waitcnt_d;
            memerr_q   <= memerr_d;
            stallcnt_q <= stallcnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a rule-level reference model checked every cycle.
module tb_hazard_unit;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = 15;

    logic clk, reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, bneD, jumpD, pcsrcD, memreqM, memreadyM;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic forwardAD, forwardBD, memerr;
    logic [1:0] forwardAE, forwardBE;
    logic [CNT_W-1:0] stallcnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: miss in progress, its stalled-cycle count, error flag, stall total.
    bit m_waiting, m_err;
    int m_streak, m_cnt;

    hazard_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .bneD(bneD), .jumpD(jumpD), .pcsrcD(pcsrcD),
        .memreqM(memreqM), .memreadyM(memreadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memerr(memerr), .stallcnt(stallcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd_e(input logic [4:0] r);
        if (r != 0 && regwriteM && r == writeregM) return 2;
        if (r != 0 && regwriteW && r == writeregW) return 1;
        return 0;
    endfunction

    function automatic bit e_lw();
        return memtoregE && (rtE == rsD || rtE == rtD);
    endfunction

    function automatic bit e_br();
        bit e_hit, m_hit;
        e_hit = regwriteE && (writeregE == rsD || writeregE == rtD);
        m_hit = memtoregM && (writeregM == rsD || writeregM == rtD);
        return (branchD || bneD) && (e_hit || m_hit);
    endfunction

    function automatic bit e_mem();
        return m_err || m_waiting || (memreqM && !memreadyM);
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_err = 0; m_streak = 0; m_cnt = 0;
    endtask

    task automatic check_all();
        bit hz, ms;
        hz = e_lw() || e_br();
        ms = e_mem();
        chk("stallF", stallF, hz || ms);
        chk("stallD", stallD, hz || ms);
        chk("stallE", stallE, ms);
        chk("stallM", stallM, ms);
        chk("flushW", flushW, ms);
        chk("flushE", flushE, hz && !ms);
        chk("flushD", flushD, (pcsrcD || jumpD) && !(hz || ms));
        chk("forwardAE", forwardAE, fwd_e(rsE));
        chk("forwardBE", forwardBE, fwd_e(rtE));
        chk("forwardAD", forwardAD, rsD != 0 && regwriteM && rsD == writeregM);
        chk("forwardBD", forwardBD, rtD != 0 && regwriteM && rtD == writeregM);
        chk("memerr", memerr, m_err);
        chk("stallcnt", stallcnt, m_cnt);
    endtask

    task automatic model_edge();
        bit st;
        if (reset) begin
            model_reset();
            return;
        end
        st = e_lw() || e_br() || e_mem();
        if (st && m_cnt < CNT_MAX) m_cnt++;
        if (!m_err) begin
            if (m_waiting) begin
                if (memreadyM) m_waiting = 0;
                else begin
                    m_streak++;
                    if (m_streak >= MAX_WAIT) m_err = 1;
                end
            end else if (memreqM && !memreadyM) begin
                m_waiting = 1;
                m_streak  = 1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic clear_in();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; bneD = 0; jumpD = 0; pcsrcD = 0;
        memreqM = 0; memreadyM = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_in();
        do_reset();
        settle();
        chk("rst_stallcnt", stallcnt, 0);
        chk("rst_memerr", memerr, 0);
        chk("rst_stallF", stallF, 0);
        adv();

        // Load-use
        memtoregE = 1; rtE = 8; rsD = 8;
        settle();
        chk("lw_stallF", stallF, 1);
        chk("lw_flushE", flushE, 1);
        chk("lw_stallE", stallE, 0);
        adv();
        clear_in();
        settle();
        chk("lw_cnt", stallcnt, 1);
        adv();

        // Forward priority
        rsE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
        settle(); chk("fwd_m", forwardAE, 2'b10); adv();
        regwriteM = 0;
        settle(); chk("fwd_w", forwardAE, 2'b01); adv();
        rsE = 0;
        settle(); chk("fwd_0", forwardAE, 2'b00); adv();
        rtE = 5; regwriteM = 1;
        tick();
        clear_in();

        // Branch hazard, then resolved by D-stage forwarding from M
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        settle();
        chk("br_stallD", stallD, 1);
        chk("br_flushE", flushE, 1);
        adv();
        regwriteE = 0; writeregM = 3; regwriteM = 1;
        settle();
        chk("br_nostall", stallD, 0);
        chk("br_fwdAD", forwardAD, 1);
        adv();
        bneD = 1; branchD = 0; memtoregM = 1; rtD = 3; rsD = 9;
        tick();
        clear_in();
        pcsrcD = 1;
        settle(); chk("flushD", flushD, 1); adv();
        memtoregE = 1; rtE = 4; rtD = 4;
        tick();
        clear_in();

        // Memory wait resolved after 3 not-ready cycles
        do_reset();
        memreqM = 1; memreadyM = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_stallM", stallM, 1);
            adv();
        end
        memreadyM = 1;
        settle(); chk("mw_last", stallF, 1); adv();
        memreqM = 0; memreadyM = 0;
        settle();
        chk("mw_idle", stallF, 0);
        chk("mw_memerr", memerr, 0);
        chk("mw_cnt", stallcnt, 4);
        adv();
        memreqM = 1; memreadyM = 1;
        settle(); chk("hit_nostall", stallF, 0); adv();
        clear_in();

        // Timeout into sticky ERROR, then async reset out of it
        do_reset();
        memreqM = 1; memreadyM = 0;
        repeat (4) tick();
        memreqM = 0;
        settle();
        chk("to_memerr", memerr, 1);
        chk("to_stallE", stallE, 1);
        adv();
        memreadyM = 1;
        repeat (2) tick();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("ar_stallF", stallF, 0);
        chk("ar_memerr", memerr, 0);
        adv();
        reset = 1'b0;
        clear_in();

        // Load-use together with memory stall, then counter saturation
        do_reset();
        memtoregE = 1; rtE = 7; rsD = 7; memreqM = 1; memreadyM = 0;
        settle();
        chk("sim_flushE", flushE, 0);
        chk("sim_stallE", stallE, 1);
        adv();
        memreadyM = 1;
        tick();
        memreqM = 0;
        repeat (18) tick();
        settle();
        chk("sat_cnt", stallcnt, 15);
        adv();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
